regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
- Owns the single register-file write port.
- Shares that port between the pipeline write-back stage (primary) and an auxiliary multi-cycle requester (secondary, e.g. divider or I/O unit) using a valid/ready handshake.
- Tracks registers with outstanding auxiliary writes in a scoreboard, and raises a RAW stall to decode.
- Bounds auxiliary starvation by freezing the pipeline for one cycle.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles an aux request may wait before a forced grant (range 1..15).
- ZERO_REG_RO, 1: when 1, writes and claims to register 0 are discarded.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_we  in  1  write-back stage write request.
- wb_rd  in  3  write-back destination register.
- wb_data  in  16  write-back data.
- aux_valid  in  1  auxiliary write request valid.
- aux_rd  in  3  auxiliary destination register.
- aux_data  in  16  auxiliary write data.
- aux_ready  out  1  auxiliary request accepted this cycle (combinational).
- aux_claim  in  1  aux unit issued an op that will later write aux_claim_rd.
- aux_claim_rd  in  3  register claimed.
- rs1  in  3  decode source register 1.
- rs2  in  3  decode source register 2.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  3  register-file write address (registered).
- rf_wdata  out  16  register-file write data (registered).
- pending  out  8  scoreboard, one bit per register (registered).
- raw_stall  out  1  rs1 or rs2 has a pending aux write (combinational).
- pipe_stall  out  1  freeze the pipeline including the MEM/WB register (combinational).

Behaviour:
- Reset (reset=0, asynchronous) clears the following; all other outputs follow from this state:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - pending=0.
  - starvation counter=0.
  - state=ARB.
- Effective requests:
  - wb_eff = wb_we and not (ZERO_REG_RO and wb_rd==0).
  - aux_eff = aux_valid and not (ZERO_REG_RO and aux_rd==0).
  - A zero-reg aux request is still handshaken (aux_ready=1) but produces no write.
- Handshake: aux_valid is held with stable aux_rd/aux_data until the cycle aux_ready=1; the transfer occurs on that edge.
- State ARB:
  - wb_eff=1: grant WB; aux_ready=0.
  - wb_eff=0: aux_ready=aux_valid; grant aux if aux_eff.
  - Counter increments on each cycle with aux_valid=1 and aux_ready=0, saturating at STARVE_LIMIT.
  - Counter clears on any aux acceptance or when aux_valid=0.
  - Next-state FORCE when the incremented count reaches STARVE_LIMIT.
- State FORCE (exactly one cycle):
  - pipe_stall=aux_valid.
  - aux_ready=aux_valid; grant aux regardless of wb_eff. The WB request is ignored this cycle; it is not lost, because the held MEM/WB register presents it again.
  - Next state ARB; counter cleared.
  - If aux_valid=0 in FORCE, there is no write and no stall.
- Grant to port: one cycle latency. The winning rd/data appears on rf_waddr/rf_wdata with rf_we=1 on the edge after the request cycle. With no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- Scoreboard, per edge:
  - Set pending[aux_claim_rd] on aux_claim (ignored for reg 0 when ZERO_REG_RO).
  - Clear pending[aux_rd] on aux acceptance.
  - Same register set and cleared in the same cycle: set wins.
  - Claim of an already-pending register: stays set.
- raw_stall = pending[rs1] | pending[rs2]. It uses the registered pending value and does not look ahead at same-cycle clears.
- WB writes never touch the scoreboard.
- Reset asserted mid-FORCE: returns to ARB; any in-flight aux request must be re-presented after reset.

Test Plan:
- Reset then idle:
  - Stimulus: reset low 2 cycles, then high with no requests.
  - Required: all outputs 0, pending=8'h00, raw_stall=0 for 10 cycles.
- WB only:
  - Stimulus: wb_we=1, wb_rd=3, wb_data=16'hBEEF.
  - Required: next edge rf_we=1, rf_waddr=3, rf_wdata=16'hBEEF.
  - Stimulus: wb_rd=0 with ZERO_REG_RO=1.
  - Required: rf_we=0.
- Aux when idle:
  - Stimulus: aux_claim, aux_claim_rd=5.
  - Required: pending=8'h20; raw_stall=1 when rs1=5.
  - Stimulus: later aux_valid with rd=5, data=16'h1234, wb_we=0.
  - Required: aux_ready=1; next edge rf_waddr=5, rf_wdata=16'h1234; pending=0.
- Starvation:
  - Stimulus: wb_we=1 continuously, aux_valid=1, STARVE_LIMIT=4.
  - Required: aux_ready=0 for 4 cycles; 5th cycle FORCE with pipe_stall=1 and aux_ready=1; aux write lands; WB resumes the next cycle with counter=0.
- Simultaneous claim/clear:
  - Stimulus: aux accepted for rd=2 while aux_claim_rd=2.
  - Required: pending[2] remains 1.
- Async reset during FORCE:
  - Stimulus: drop reset in the FORCE cycle.
  - Required: pipe_stall, rf_we and pending go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wport_arbiter_if.sv
// regfile_wport_arbiter_if: write-port, aux handshake, scoreboard and stall signals of the register-file write arbiter.
interface regfile_wport_arbiter_if;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        aux_valid;
  logic [2:0]  aux_rd;
  logic [15:0] aux_data;
  logic        aux_ready;
  logic        aux_claim;
  logic [2:0]  aux_claim_rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  pending;
  logic        raw_stall;
  logic        pipe_stall;
  modport slave (
    input  wb_we, wb_rd, wb_data, aux_valid, aux_rd, aux_data, aux_claim, aux_claim_rd, rs1, rs2,
    output aux_ready, rf_we, rf_waddr, rf_wdata, pending, raw_stall, pipe_stall
  );
  modport master (
    output wb_we, wb_rd, wb_data, aux_valid, aux_rd, aux_data, aux_claim, aux_claim_rd, rs1, rs2,
    input  aux_ready, rf_we, rf_waddr, rf_wdata, pending, raw_stall, pipe_stall
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register-file write port between write-back and an aux unit,
// with an aux scoreboard for RAW stalls and a one-cycle pipeline freeze to bound aux starvation.
module regfile_wport_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter bit ZERO_REG_RO  = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_wport_arbiter_if.slave bus
);
  typedef enum logic {S_ARB, S_FORCE} state_t;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_waddr;
  logic [15:0] r_wdata;
  logic [7:0]  r_pending;
  logic        w_wb_eff, w_aux_eff, w_force, w_acc, w_starve, w_grant_aux, w_grant_wb;
  logic [3:0]  w_cnt_inc;
  logic [7:0]  w_clr, w_set;
  always_comb begin
    w_wb_eff    = bus.wb_we && !(ZERO_REG_RO && bus.wb_rd == 3'd0);
    w_aux_eff   = bus.aux_valid && !(ZERO_REG_RO && bus.aux_rd == 3'd0);
    w_force     = r_state == S_FORCE;
    w_acc       = bus.aux_valid && (w_force || !w_wb_eff);
    w_grant_aux = w_acc && w_aux_eff;
    w_grant_wb  = w_wb_eff && !w_force;
    w_starve    = bus.aux_valid && !w_acc;
    w_cnt_inc   = (r_cnt == 4'(STARVE_LIMIT)) ? r_cnt : r_cnt + 4'd1;
    w_clr       = w_acc ? 8'd1 << bus.aux_rd : 8'd0;
    w_set       = (bus.aux_claim && !(ZERO_REG_RO && bus.aux_claim_rd == 3'd0)) ? 8'd1 << bus.aux_claim_rd : 8'd0;
  end
  assign bus.aux_ready  = w_acc;
  assign bus.pipe_stall = w_force && bus.aux_valid;
  assign bus.raw_stall  = r_pending[bus.rs1] | r_pending[bus.rs2];
  assign bus.rf_we      = r_we;
  assign bus.rf_waddr   = r_waddr;
  assign bus.rf_wdata   = r_wdata;
  assign bus.pending    = r_pending;
  // Set is OR-ed in after the clear so a same-cycle claim of the accepted register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_ARB;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_waddr   <= 3'd0;
      r_wdata   <= 16'd0;
      r_pending <= 8'd0;
    end else begin
      r_state   <= (w_starve && w_cnt_inc == 4'(STARVE_LIMIT)) ? S_FORCE : S_ARB;
      r_cnt     <= w_starve ? w_cnt_inc : 4'd0;
      r_we      <= w_grant_aux || w_grant_wb;
      r_waddr   <= w_grant_aux ? bus.aux_rd : w_grant_wb ? bus.wb_rd : r_waddr;
      r_wdata   <= w_grant_aux ? bus.aux_data : w_grant_wb ? bus.wb_data : r_wdata;
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model of the write-port arbitration rules.
module tb_regfile_wport_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic armed = 1'b0;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  regfile_wport_arbiter_if bus();
  regfile_wport_arbiter #(.STARVE_LIMIT(LIM), .ZERO_REG_RO(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Model state: how long the current aux request has waited, whether this cycle is the forced grant,
  // which registers still await an aux write, and what the write port last showed.
  int          m_wait = 0;
  bit          m_force = 1'b0;
  bit [7:0]    m_pend = 8'h00;
  bit          m_we = 1'b0;
  bit [2:0]    m_addr = 3'd0;
  bit [15:0]   m_data = 16'd0;

  wire e_wb     = bus.wb_we && bus.wb_rd != 3'd0;
  wire e_aux    = bus.aux_valid && bus.aux_rd != 3'd0;
  wire e_ready  = bus.aux_valid && (m_force || !e_wb);
  wire e_pstall = m_force && bus.aux_valid;
  wire e_raw    = m_pend[bus.rs1] | m_pend[bus.rs2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait = 0; m_force = 1'b0; m_pend = 8'h00; m_we = 1'b0; m_addr = 3'd0; m_data = 16'd0;
    end else begin
      bit rdy, aux, wb, frc;
      rdy = e_ready; aux = e_aux; wb = e_wb; frc = m_force;
      if (rdy && aux) begin m_we = 1'b1; m_addr = bus.aux_rd; m_data = bus.aux_data; end
      else if (wb && !frc) begin m_we = 1'b1; m_addr = bus.wb_rd; m_data = bus.wb_data; end
      else m_we = 1'b0;
      if (rdy) m_pend[bus.aux_rd] = 1'b0;
      if (bus.aux_claim && bus.aux_claim_rd != 3'd0) m_pend[bus.aux_claim_rd] = 1'b1;
      if (frc) begin m_force = 1'b0; m_wait = 0; end
      else if (bus.aux_valid && !rdy) begin m_wait++; m_force = (m_wait >= LIM); end
      else m_wait = 0;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("aux_ready", 16'(bus.aux_ready), 16'(e_ready));
    chk("pipe_stall", 16'(bus.pipe_stall), 16'(e_pstall));
    chk("raw_stall", 16'(bus.raw_stall), 16'(e_raw));
    chk("rf_we", 16'(bus.rf_we), 16'(m_we));
    chk("rf_waddr", 16'(bus.rf_waddr), 16'(m_addr));
    chk("rf_wdata", bus.rf_wdata, m_data);
    chk("pending", 16'(bus.pending), 16'(m_pend));
  end

  task automatic idle();
    bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.aux_valid = 0; bus.aux_rd = 0; bus.aux_data = 0;
    bus.aux_claim = 0; bus.aux_claim_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit acc;
    idle();
    #1 rst_n = 1'b0;
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) step();
    chk("idle_pending", 16'(bus.pending), 16'h0000);
    chk("idle_rf_we", 16'(bus.rf_we), 16'h0000);
    // write-back only
    bus.wb_we = 1; bus.wb_rd = 3; bus.wb_data = 16'hBEEF;
    step();
    chk("wb_we", 16'(bus.rf_we), 16'h0001);
    chk("wb_addr", 16'(bus.rf_waddr), 16'h0003);
    chk("wb_data", bus.rf_wdata, 16'hBEEF);
    bus.wb_rd = 0;
    step();
    chk("wb_zero_we", 16'(bus.rf_we), 16'h0000);
    chk("wb_zero_hold", 16'(bus.rf_waddr), 16'h0003);
    bus.wb_we = 0;
    // claim then aux write of r5
    bus.aux_claim = 1; bus.aux_claim_rd = 5;
    step();
    bus.aux_claim = 0;
    chk("claim_pending", 16'(bus.pending), 16'h0020);
    bus.rs1 = 5;
    #1 chk("claim_raw", 16'(bus.raw_stall), 16'h0001);
    bus.rs1 = 0;
    bus.aux_valid = 1; bus.aux_rd = 5; bus.aux_data = 16'h1234;
    #1 chk("aux_idle_ready", 16'(bus.aux_ready), 16'h0001);
    step();
    bus.aux_valid = 0;
    chk("aux_addr", 16'(bus.rf_waddr), 16'h0005);
    chk("aux_data", bus.rf_wdata, 16'h1234);
    chk("aux_pending_clr", 16'(bus.pending), 16'h0000);
    // starvation under continuous write-back
    bus.wb_we = 1; bus.wb_rd = 1; bus.wb_data = 16'h1111;
    bus.aux_valid = 1; bus.aux_rd = 6; bus.aux_data = 16'h6666;
    for (int i = 0; i < LIM; i++) begin
      #1 chk("starve_ready", 16'(bus.aux_ready), 16'h0000);
      step();
    end
    #1 chk("force_stall", 16'(bus.pipe_stall), 16'h0001);
    chk("force_ready", 16'(bus.aux_ready), 16'h0001);
    step();
    bus.aux_valid = 0;
    chk("force_addr", 16'(bus.rf_waddr), 16'h0006);
    chk("force_data", bus.rf_wdata, 16'h6666);
    step();
    chk("wb_resume", 16'(bus.rf_waddr), 16'h0001);
    bus.wb_we = 0;
    // same-cycle claim and clear of r2
    bus.aux_claim = 1; bus.aux_claim_rd = 2;
    step();
    bus.aux_valid = 1; bus.aux_rd = 2; bus.aux_data = 16'h2222;
    step();
    chk("set_wins", 16'(bus.pending[2]), 16'h0001);
    bus.aux_claim = 0;
    step();
    bus.aux_valid = 0;
    chk("late_clear", 16'(bus.pending[2]), 16'h0000);
    // async reset in the forced cycle
    bus.aux_claim = 1; bus.aux_claim_rd = 4;
    bus.wb_we = 1; bus.wb_rd = 3; bus.wb_data = 16'h3333;
    bus.aux_valid = 1; bus.aux_rd = 7; bus.aux_data = 16'h7777;
    step();
    bus.aux_claim = 0;
    repeat (LIM - 1) step();
    #1 chk("rst_force_stall", 16'(bus.pipe_stall), 16'h0001);
    rst_n = 1'b0;
    #1 chk("rst_pipe_stall", 16'(bus.pipe_stall), 16'h0000);
    chk("rst_rf_we", 16'(bus.rf_we), 16'h0000);
    chk("rst_pending", 16'(bus.pending), 16'h0000);
    idle();
    step();
    rst_n = 1'b1;
    // randomized traffic with a legal aux handshake, at three write-back densities
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        acc = bus.aux_valid && bus.aux_ready;
        @(posedge clk);
        #2;
        if (!bus.aux_valid || acc) begin
          bus.aux_valid = $urandom_range(0, 1) == 1;
          bus.aux_rd = 3'($urandom);
          bus.aux_data = 16'($urandom);
        end
        bus.wb_we = (ph == 1) ? 1'b1 : (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        bus.wb_rd = 3'($urandom);
        bus.wb_data = 16'($urandom);
        bus.aux_claim = $urandom_range(0, 3) == 0;
        bus.aux_claim_rd = 3'($urandom);
        bus.rs1 = 3'($urandom);
        bus.rs2 = 3'($urandom);
      end
    end
    idle();
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
